// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types and defaults
package fetch_pkg;
  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_ERR   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_ALIGN_MASK     = 32'hFFFF_FFFC;
  localparam int          FETCH_FIFO_DEPTH_DEF = 2;
  localparam int          FETCH_MAX_OUTST_DEF  = 2;
endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory request/response bus
interface instr_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (output o_imem_req, o_imem_addr,
                  input  i_imem_gnt, i_imem_rvalid, i_imem_rdata);
  modport slave  (input  o_imem_req, o_imem_addr,
                  output i_imem_gnt, i_imem_rvalid, i_imem_rdata);
endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - fetch_fifo: instruction buffer holding {instr, pc}
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_q];
  assign do_pop  = i_pop & ~o_empty;
  // a full buffer still accepts a push when the head leaves in the same cycle
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clr) mem_q[wr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (i_clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with credit-based request issue
// Optional misaligned-fetch trap enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH_DEF,
  parameter int MAX_OUTST  = FETCH_MAX_OUTST_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_pc,
  input  logic         i_flush,
  output logic         o_pc_advance,
  instr_fetch_if.master imem,
  output logic         o_instr_valid,
  output logic [31:0]  o_instr,
  output logic [31:0]  o_instr_pc,
  input  logic         i_instr_ready,
  output logic         o_misalign_err
);
  localparam int TW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t   state_q, state_d;
  logic [OCW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [TW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]    tag_q [MAX_OUTST];
  logic           err_q, err_d;

  logic [FCW-1:0] fifo_cnt;
  logic           fifo_full, fifo_empty;
  logic [63:0]    fifo_head;
  logic           credit_ok, issue_ok, req, fire, rsp, push, pop, misalign;

  // credits count in-flight requests against free buffer slots so a response never overflows
  assign credit_ok = (outst_q < OCW'(MAX_OUTST)) && !fifo_full &&
                     ((int'(fifo_cnt) + int'(outst_q)) < FIFO_DEPTH);
  assign issue_ok  = i_rst && (state_q == FS_RUN) && !i_flush && credit_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign         = issue_ok && (i_pc[1:0] != 2'b00);
  assign req              = issue_ok && !misalign;
  assign imem.o_imem_addr = i_rst ? i_pc : '0;
  assign o_misalign_err   = err_q;
`else
  assign misalign         = 1'b0;
  assign req              = issue_ok;
  assign imem.o_imem_addr = i_rst ? (i_pc & FETCH_ALIGN_MASK) : '0;
  assign o_misalign_err   = 1'b0;
`endif

  assign imem.o_imem_req = req;
  assign fire            = req & imem.i_imem_gnt;
  assign o_pc_advance    = fire;
  assign rsp             = imem.i_imem_rvalid && (outst_q != '0);
  assign push            = rsp && (discard_q == '0) && !i_flush;
  assign pop             = o_instr_valid & i_instr_ready;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    err_d     = err_q;
    outst_d   = outst_q + OCW'(fire) - OCW'(rsp);
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    if (fire) tag_wr_d = (tag_wr_q == TW'(MAX_OUTST - 1)) ? '0 : tag_wr_q + 1'b1;
    if (rsp)  tag_rd_d = (tag_rd_q == TW'(MAX_OUTST - 1)) ? '0 : tag_rd_q + 1'b1;
    if (i_flush) begin
      discard_d = outst_q - OCW'(rsp);
      state_d   = (discard_d != '0) ? FS_DRAIN : FS_RUN;
      err_d     = 1'b0;
    end else if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
      if (discard_d == '0) state_d = FS_RUN;
    end
    if (misalign) begin
      state_d = FS_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= FS_RUN;
      outst_q   <= '0;
      discard_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fire) tag_q[tag_wr_q] <= imem.o_imem_addr;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_flush),
    .i_push  (push),
    .i_data  ({imem.i_imem_rdata, tag_q[tag_rd_q]}),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_count (fifo_cnt),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_instr_valid = !fifo_empty;
  assign o_instr       = fifo_head[63:32];
  assign o_instr_pc    = fifo_head[31:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_flush = 1'b0;
  logic        i_instr_ready = 1'b0;
  logic        o_pc_advance, o_instr_valid, o_misalign_err;
  logic [31:0] o_instr, o_instr_pc;

  instr_fetch_if u_if ();

  instr_fetch dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pc           (i_pc),
    .i_flush        (i_flush),
    .o_pc_advance   (o_pc_advance),
    .imem           (u_if),
    .o_instr_valid  (o_instr_valid),
    .o_instr        (o_instr),
    .o_instr_pc     (o_instr_pc),
    .i_instr_ready  (i_instr_ready),
    .o_misalign_err (o_misalign_err)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  int          adv_bad, n_grant;
  logic        rsp_en;
  logic [31:0] mem_q [$];
  logic [31:0] dpc_q [$];
  logic [31:0] dins_q [$];
  logic        last_req, last_adv, last_err, last_valid;
  logic [31:0] last_addr, last_ipc;

  // memory responds in order, one per cycle, data = ~address
  task automatic tick();
    logic [31:0] a;
    @(negedge i_clk);
    last_req   = u_if.o_imem_req;
    last_addr  = u_if.o_imem_addr;
    last_adv   = o_pc_advance;
    last_err   = o_misalign_err;
    last_valid = o_instr_valid;
    last_ipc   = o_instr_pc;
    if (o_pc_advance !== (u_if.o_imem_req & u_if.i_imem_gnt)) adv_bad++;
    if (u_if.o_imem_req && u_if.i_imem_gnt) begin
      n_grant++;
      mem_q.push_back(u_if.o_imem_addr);
    end
    if (o_instr_valid && i_instr_ready) begin
      dpc_q.push_back(o_instr_pc);
      dins_q.push_back(o_instr);
    end
    @(posedge i_clk);
    #1;
    if (last_adv) i_pc = i_pc + 32'd4;
    if (rsp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      u_if.i_imem_rvalid = 1'b1;
      u_if.i_imem_rdata  = ~a;
    end else begin
      u_if.i_imem_rvalid = 1'b0;
      u_if.i_imem_rdata  = '0;
    end
  endtask

  task automatic reset_dut(input logic [31:0] start_pc);
    i_rst = 1'b0;
    i_flush = 1'b0;
    i_instr_ready = 1'b0;
    u_if.i_imem_gnt = 1'b0;
    u_if.i_imem_rvalid = 1'b0;
    u_if.i_imem_rdata = '0;
    rsp_en = 1'b1;
    mem_q.delete();
    dpc_q.delete();
    dins_q.delete();
    adv_bad = 0;
    n_grant = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_pc = start_pc;
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_pc = 32'h44;
    u_if.i_imem_gnt = 1'b1;
    u_if.i_imem_rvalid = 1'b0;
    i_instr_ready = 1'b1;
    @(negedge i_clk);
    total++; if (u_if.o_imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", u_if.o_imem_req); end
    total++; if (u_if.o_imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", u_if.o_imem_addr); end
    total++; if (o_pc_advance !== 1'b0) begin bad++; $display("FAIL reset_adv got=%b want=0", o_pc_advance); end
    total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_instr_valid); end
    total++; if (o_misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", o_misalign_err); end
  endtask

  task automatic test_stream();
    reset_dut(32'h0);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b1;
    tick();
    total++; if (last_req !== 1'b1) begin bad++; $display("FAIL stream_first_req got=%b want=1", last_req); end
    total++; if (last_addr !== 32'h0) begin bad++; $display("FAIL stream_first_addr got=%h want=0", last_addr); end
    total++; if (last_adv !== 1'b1) begin bad++; $display("FAIL stream_first_adv got=%b want=1", last_adv); end
    repeat (11) tick();
    total++;
    if (dpc_q.size() < 3) begin
      bad++; $display("FAIL stream_count got=%0d want>=3", dpc_q.size());
    end else begin
      total++; if (dpc_q[0] !== 32'h0) begin bad++; $display("FAIL stream_pc0 got=%h want=0", dpc_q[0]); end
      total++; if (dpc_q[1] !== 32'h4) begin bad++; $display("FAIL stream_pc1 got=%h want=4", dpc_q[1]); end
      total++; if (dpc_q[2] !== 32'h8) begin bad++; $display("FAIL stream_pc2 got=%h want=8", dpc_q[2]); end
      total++; if (dins_q[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stream_ins0 got=%h want=ffffffff", dins_q[0]); end
      total++; if (dins_q[1] !== 32'hFFFF_FFFB) begin bad++; $display("FAIL stream_ins1 got=%h want=fffffffb", dins_q[1]); end
      total++; if (dins_q[2] !== 32'hFFFF_FFF7) begin bad++; $display("FAIL stream_ins2 got=%h want=fffffff7", dins_q[2]); end
    end
    total++; if (adv_bad !== 0) begin bad++; $display("FAIL stream_adv_vs_grant got=%0d want=0", adv_bad); end
  endtask

  task automatic test_backpressure();
    reset_dut(32'h0);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b0;
    repeat (6) tick();
    total++; if (n_grant !== 2) begin bad++; $display("FAIL bp_grants got=%0d want=2", n_grant); end
    total++; if (last_req !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%b want=0", last_req); end
    total++; if (last_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", last_valid); end
    total++; if (last_ipc !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%h want=0", last_ipc); end
    total++; if (dpc_q.size() !== 0) begin bad++; $display("FAIL bp_no_deliver got=%0d want=0", dpc_q.size()); end
    i_instr_ready = 1'b1;
    repeat (4) tick();
    total++;
    if (dpc_q.size() < 2) begin
      bad++; $display("FAIL bp_drain_count got=%0d want>=2", dpc_q.size());
    end else begin
      total++; if (dpc_q[0] !== 32'h0) begin bad++; $display("FAIL bp_drain_pc0 got=%h want=0", dpc_q[0]); end
      total++; if (dpc_q[1] !== 32'h4) begin bad++; $display("FAIL bp_drain_pc1 got=%h want=4", dpc_q[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    reset_dut(32'h0);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b0;
    repeat (4) tick();
    total++; if (last_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", last_valid); end
    i_rst = 1'b0;
    #2;
    total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", o_instr_valid); end
    total++; if (u_if.o_imem_req !== 1'b0) begin bad++; $display("FAIL mid_async_req got=%b want=0", u_if.o_imem_req); end
  endtask

  task automatic test_gnt_stall();
    reset_dut(32'h10);
    u_if.i_imem_gnt = 1'b0;
    i_instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (last_req !== 1'b1) begin bad++; $display("FAIL stall_req[%0d] got=%b want=1", i, last_req); end
      total++; if (last_addr !== 32'h10) begin bad++; $display("FAIL stall_addr[%0d] got=%h want=10", i, last_addr); end
      total++; if (last_adv !== 1'b0) begin bad++; $display("FAIL stall_adv[%0d] got=%b want=0", i, last_adv); end
    end
    u_if.i_imem_gnt = 1'b1;
    tick();
    total++; if (last_adv !== 1'b1) begin bad++; $display("FAIL stall_gnt_adv got=%b want=1", last_adv); end
    total++; if (n_grant !== 1) begin bad++; $display("FAIL stall_grants got=%0d want=1", n_grant); end
  endtask

  task automatic test_flush_outstanding();
    reset_dut(32'h20);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b1;
    rsp_en = 1'b0;
    repeat (2) tick();
    total++; if (n_grant !== 2) begin bad++; $display("FAIL fl_outst_grants got=%0d want=2", n_grant); end
    rsp_en = 1'b1;
    i_flush = 1'b1;
    tick();
    total++; if (last_req !== 1'b0) begin bad++; $display("FAIL fl_req_withdrawn got=%b want=0", last_req); end
    i_flush = 1'b0;
    i_pc = 32'h80;
    repeat (8) tick();
    total++;
    if (dpc_q.size() < 1) begin
      bad++; $display("FAIL fl_deliver_count got=%0d want>=1", dpc_q.size());
    end else begin
      total++; if (dpc_q[0] !== 32'h80) begin bad++; $display("FAIL fl_first_pc got=%h want=80", dpc_q[0]); end
      total++; if (dins_q[0] !== 32'hFFFF_FF7F) begin bad++; $display("FAIL fl_first_ins got=%h want=ffffff7f", dins_q[0]); end
    end
  endtask

  task automatic test_flush_rvalid();
    reset_dut(32'h40);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b1;
    tick();
    i_flush = 1'b1;
    tick();
    total++; if (last_req !== 1'b0) begin bad++; $display("FAIL flrv_req got=%b want=0", last_req); end
    i_flush = 1'b0;
    i_pc = 32'h60;
    tick();
    total++; if (last_req !== 1'b1) begin bad++; $display("FAIL flrv_next_req got=%b want=1", last_req); end
    total++; if (last_addr !== 32'h60) begin bad++; $display("FAIL flrv_next_addr got=%h want=60", last_addr); end
    repeat (4) tick();
    total++;
    if (dpc_q.size() < 1) begin
      bad++; $display("FAIL flrv_count got=%0d want>=1", dpc_q.size());
    end else begin
      total++; if (dpc_q[0] !== 32'h60) begin bad++; $display("FAIL flrv_first_pc got=%h want=60", dpc_q[0]); end
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    reset_dut(32'h102);
    u_if.i_imem_gnt = 1'b1;
    i_instr_ready = 1'b1;
    tick();
    total++; if (last_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b want=0", last_req); end
    tick();
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", last_err); end
    total++; if (last_req !== 1'b0) begin bad++; $display("FAIL mis_err_req got=%b want=0", last_req); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_pc = 32'h200;
    tick();
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", last_err); end
    total++; if (last_req !== 1'b1) begin bad++; $display("FAIL mis_resume_req got=%b want=1", last_req); end
    total++; if (last_addr !== 32'h200) begin bad++; $display("FAIL mis_resume_addr got=%h want=200", last_addr); end
  endtask
`else
  task automatic test_addr_align();
    reset_dut(32'h102);
    u_if.i_imem_gnt = 1'b0;
    i_instr_ready = 1'b1;
    tick();
    total++; if (last_req !== 1'b1) begin bad++; $display("FAIL align_req got=%b want=1", last_req); end
    total++; if (last_addr !== 32'h100) begin bad++; $display("FAIL align_addr got=%h want=100", last_addr); end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL align_err got=%b want=0", last_err); end
  endtask
`endif

  initial begin
    u_if.i_imem_gnt = 1'b0;
    u_if.i_imem_rvalid = 1'b0;
    u_if.i_imem_rdata = '0;
    rsp_en = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_gnt_stall();
    test_flush_outstanding();
    test_flush_rvalid();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_addr_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 2, maximum granted-but-unanswered memory requests.
REQ-003 SHALL have port i_clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pc  input  32  fetch address from PC register.
REQ-006 SHALL have port i_flush  input  1  PC redirect this cycle (branch/jump taken).
REQ-007 SHALL have port o_pc_advance  output  1  pulse; PC register loads next address.
REQ-008 SHALL have port o_imem_req / o_imem_addr  output  1/32  memory request, address.
REQ-009 SHALL have port i_imem_gnt  input  1  request accepted this cycle.
REQ-010 SHALL have port i_imem_rvalid / i_imem_rdata  input  1/32  in-order response, >=1 cycle after grant.
REQ-011 SHALL have port o_instr_valid / o_instr / o_instr_pc  output  1/32/32  instruction to decode.
REQ-012 SHALL have port i_instr_ready  input  1  decode accepts; transfer when valid&ready.
REQ-013 SHALL have port o_misalign_err  output  1  sticky misaligned-fetch flag (macro only).

Function
REQ-014 SHALL drive o_imem_addr = i_pc combinationally; o_imem_req = 1 when state RUN, !i_flush, outst_cnt < MAX_OUTST, fifo_cnt + outst_cnt < FIFO_DEPTH.
REQ-015 SHALL assert o_pc_advance exactly in cycles where o_imem_req & i_imem_gnt.
REQ-016 SHALL keep o_imem_req high with stable address until granted, except withdrawal on i_flush.
REQ-017 SHALL record issued address per grant in an in-order tag queue; outst_cnt +1 on grant, -1 on rvalid, both same cycle: unchanged.
REQ-018 SHALL push {rdata, tagged pc} into FIFO on rvalid when discard_cnt == 0; o_instr_valid rises the cycle after push (1-cycle latency).
REQ-019 SHALL present FIFO head on o_instr*; pop on valid&ready; push and pop same cycle when full SHALL be legal, count unchanged.
REQ-020 SHALL never overflow FIFO (credit rule REQ-014 guarantees); rvalid with outst_cnt == 0 SHALL be ignored.
REQ-021 SHALL on i_flush: clear FIFO, set discard_cnt = outst_cnt - i_imem_rvalid, drop any response that cycle, enter DRAIN if result > 0, else RUN.
REQ-022 SHALL in DRAIN drop each rvalid, decrement discard_cnt, return to RUN on reaching 0; no requests in DRAIN.
REQ-023 SHALL treat i_flush in DRAIN as REQ-021 (recompute discard_cnt).
REQ-024 SHALL implement FSM states RUN, DRAIN, ERR; ERR reachable only per REQ-029.

Reset
REQ-025 SHALL on !i_rst clear FIFO, tag queue, outst_cnt, discard_cnt, state=RUN, all outputs 0.
REQ-026 SHALL take reset immediately mid-transaction; responses to pre-reset grants are the memory's responsibility to suppress.
REQ-027 SHALL issue first request in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL compile misalign checking only when FETCH_MISALIGN_CHECK_EN is defined.
REQ-029 With macro: i_pc[1:0] != 0 when request would issue SHALL suppress request, set o_misalign_err, enter ERR; ERR left only by i_flush (flag cleared) or reset.
REQ-030 Without macro: o_imem_addr[1:0] forced 0, o_misalign_err tied 0, ERR absent.

Structure
REQ-031 SHALL put state enum fetch_state_t, FETCH_ALIGN_MASK and default depths in shared package fetch_pkg.
REQ-032 SHALL implement instruction buffer as sub-module fetch_fifo (data+pc, count, full/empty).

Verification
REQ-033 Reset then gnt every cycle, rvalid 1 cycle later, ready=1 -> pcs 0x0,0x4,0x8 delivered one per cycle, o_pc_advance steady.
REQ-034 ready=0 for 6 cycles -> FIFO holds 2 entries, req drops, exactly 2 grants; ready=1 -> 0x0,0x4 drained in order.
REQ-035 gnt held low 3 cycles at pc 0x10 -> req, addr 0x10 stable, no o_pc_advance until gnt.
REQ-036 Two outstanding (0x20,0x24), i_flush with pc 0x80 -> both responses dropped, next delivered o_instr_pc = 0x80.
REQ-037 i_flush same cycle as rvalid with outst_cnt=1 -> response dropped, discard_cnt=0, RUN, request issued next cycle.
REQ-038 Macro on, i_pc=0x102 -> no req, o_misalign_err=1; i_flush with pc 0x200 -> flag 0, fetch resumes at 0x200.
